prefix_decoder: RTL and testbench

PREFIX_DECODER -- requirements
Module: prefix_decoder

---
 rtl/prefix_decoder_if.sv | 40 ++++
 rtl/prefix_decoder.sv | 151 +++++++++++++++
 tb/tb_prefix_decoder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_decoder_if.sv
// Bus between the prefetch FIFO / opcode consumer and prefix_decoder.
//
// Handshake: the FIFO side offers a byte whenever fifo_empty is low, and the
// byte leaves the FIFO on every rising clock edge where fifo_rd_en is high.
// On the consumer side, opcode and the prefix outputs are a transfer when
// opcode_valid && opcode_ready are both high at a rising edge. Once
// opcode_valid rises, it and its payload stay stable until that transfer or
// a flush.
interface prefix_decoder_if #(
    parameter int CNT_W = 4
);
    logic [7:0]       fifo_data;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             flush;
    logic             update;
    logic             segment_override;
    logic [1:0]       override_in;
    logic [7:0]       opcode;
    logic             opcode_valid;
    logic             opcode_ready;
    logic             rep;
    logic             repne;
    logic             lock;
    logic [CNT_W-1:0] prefix_count;

    // Environment side: FIFO head, flush source and opcode consumer
    modport master (
        output fifo_data, fifo_empty, flush, opcode_ready,
        input  fifo_rd_en, update, segment_override, override_in,
        input  opcode, opcode_valid, rep, repne, lock, prefix_count
    );

    // Decoder side
    modport slave (
        input  fifo_data, fifo_empty, flush, opcode_ready,
        output fifo_rd_en, update, segment_override, override_in,
        output opcode, opcode_valid, rep, repne, lock, prefix_count
    );
endinterface

// File: rtl/prefix_decoder.sv
// x86 prefix decoder: pops bytes from a prefetch FIFO, reports segment
// override prefixes as single-cycle update pulses, counts prefixes and
// presents the first non-prefix byte as a registered opcode.
// Optional feature macro: REP_LOCK_PREFIX_EN (F3h/F2h/F0h become REP/REPNE/
// LOCK prefixes; without it they are plain opcodes and the flags stay 0).
module prefix_decoder #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    prefix_decoder_if.slave  bus,
    output logic             dbg_hold_o
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             rep_q, rep_d;
    logic             repne_q, repne_d;
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             is_seg;
    logic             is_f0;
    logic             is_f2;
    logic             is_f3;
    logic             is_prefix;
    logic             pop;
    logic             handshake;

    // Classify the byte currently at the FIFO head
    always_comb begin
        is_seg = (bus.fifo_data == 8'h26) || (bus.fifo_data == 8'h2E) ||
                 (bus.fifo_data == 8'h36) || (bus.fifo_data == 8'h3E);
`ifdef REP_LOCK_PREFIX_EN
        is_f0 = (bus.fifo_data == 8'hF0);
        is_f2 = (bus.fifo_data == 8'hF2);
        is_f3 = (bus.fifo_data == 8'hF3);
`else
        is_f0 = 1'b0;
        is_f2 = 1'b0;
        is_f3 = 1'b0;
`endif
        is_prefix = is_seg || is_f0 || is_f2 || is_f3;
    end

    // A pop only happens while fetching, with data present and no flush;
    // gating with reset_n keeps the FIFO untouched while reset is held.
    assign pop       = reset_n && (state_q == FETCH) && !bus.fifo_empty && !bus.flush;
    assign handshake = (state_q == HOLD) && bus.opcode_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush always returns to FETCH
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (pop && !is_prefix) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.flush || bus.opcode_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Datapath next values: flush and handshake clear flags and count,
    // the opcode register only changes when a non-prefix byte is popped
    always_comb begin
        opcode_d = opcode_q;
        rep_d    = rep_q;
        repne_d  = repne_q;
        lock_d   = lock_q;
        count_d  = count_q;
        if (bus.flush || handshake) begin
            rep_d   = 1'b0;
            repne_d = 1'b0;
            lock_d  = 1'b0;
            count_d = '0;
        end else if (pop) begin
            if (is_prefix) begin
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (is_f3) begin
                    rep_d   = 1'b1;
                    repne_d = 1'b0;
                end
                if (is_f2) begin
                    repne_d = 1'b1;
                    rep_d   = 1'b0;
                end
                if (is_f0) begin
                    lock_d = 1'b1;
                end
            end else begin
                opcode_d = bus.fifo_data;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= 8'h00;
            rep_q    <= 1'b0;
            repne_q  <= 1'b0;
            lock_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            opcode_q <= opcode_d;
            rep_q    <= rep_d;
            repne_q  <= repne_d;
            lock_q   <= lock_d;
            count_q  <= count_d;
        end
    end

    // Outputs: pop-side signals are combinational, opcode side registered.
    // Segment number is bits [4:3] of 26h/2Eh/36h/3Eh (ES/CS/SS/DS).
    always_comb begin
        bus.fifo_rd_en       = pop;
        bus.update           = pop && is_seg;
        bus.segment_override = pop && is_seg;
        bus.override_in      = (pop && is_seg) ? bus.fifo_data[4:3] : 2'b00;
        bus.opcode           = opcode_q;
        bus.opcode_valid     = (state_q == HOLD);
        bus.rep              = rep_q;
        bus.repne            = repne_q;
        bus.lock             = lock_q;
        bus.prefix_count     = count_q;
        dbg_hold_o           = (state_q == HOLD);
    end

endmodule

// File: tb/tb_prefix_decoder.sv
// Bench for prefix_decoder: FIFO source queue, reference model checked
// every cycle at the falling edge, opcode scoreboard, directed scenarios
// with literal expectations.
module tb_prefix_decoder;
  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dbg_hold;

  prefix_decoder_if #(.CNT_W(CNT_W)) bus ();

  prefix_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .dbg_hold_o (dbg_hold)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- FIFO source ----------------
  logic [7:0] src_q[$];
  logic starve = 1'b0;
  logic pop_flag = 1'b0;

  task automatic present();
    bus.fifo_empty = starve || (src_q.size() == 0);
    bus.fifo_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  always begin
    @(posedge clk);
    if (pop_flag && src_q.size() != 0) void'(src_q.pop_front());
    #1;
    present();
  end

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] seg_tab [4] = '{8'h26, 8'h2E, 8'h36, 8'h3E};
  logic [7:0] exp_q[$];
  logic       m_hold = 1'b0;
  logic [7:0] m_opcode = 8'h00;
  int         m_cnt = 0;
  logic       m_rep = 1'b0, m_repne = 1'b0, m_lock = 1'b0;

  function automatic int seg_index(input logic [7:0] b);
    int r = -1;
    for (int i = 0; i < 4; i++) if (seg_tab[i] == b) r = i;
    return r;
  endfunction

  function automatic bit rl_prefix(input logic [7:0] b);
`ifdef REP_LOCK_PREFIX_EN
    return (b == 8'hF0) || (b == 8'hF2) || (b == 8'hF3);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    m_rep = 0; m_repne = 0; m_lock = 0; m_cnt = 0;
  endtask

  always @(negedge clk) begin
    logic       exp_rd;
    logic       exp_upd;
    int         seg;
    logic [7:0] b;
    if (!reset_n) begin
      m_hold = 0; m_opcode = 8'h00; model_clear(); exp_q.delete();
      check("rst_valid", bus.opcode_valid, 0);
      check("rst_opcode", bus.opcode, 8'h00);
      check("rst_count", bus.prefix_count, 0);
      check("rst_flags", {bus.rep, bus.repne, bus.lock}, 0);
      check("rst_rd_en", bus.fifo_rd_en, 0);
      check("rst_update", bus.update, 0);
      pop_flag = 1'b0;
    end else begin
      check("m_valid", bus.opcode_valid, m_hold);
      check("m_opcode", bus.opcode, m_opcode);
      check("m_count", bus.prefix_count, m_cnt);
      check("m_rep", bus.rep, m_rep);
      check("m_repne", bus.repne, m_repne);
      check("m_lock", bus.lock, m_lock);
      b = bus.fifo_data;
      exp_rd  = !m_hold && !bus.fifo_empty && !bus.flush;
      seg     = seg_index(b);
      exp_upd = exp_rd && (seg >= 0);
      check("m_rd_en", bus.fifo_rd_en, exp_rd);
      check("m_update", bus.update, exp_upd);
      check("m_seg_ovr", bus.segment_override, exp_upd);
      check("m_ovr_in", bus.override_in, exp_upd ? seg : 0);
      if (bus.flush) begin
        if (m_hold && exp_q.size() != 0) void'(exp_q.pop_front());
        m_hold = 0; model_clear();
      end else if (m_hold) begin
        if (bus.opcode_ready) begin
          if (exp_q.size() == 0) check("sb_empty", 1, 0);
          else check("sb_opcode", bus.opcode, exp_q.pop_front());
          m_hold = 0; model_clear();
        end
      end else if (exp_rd) begin
        if (seg >= 0 || rl_prefix(b)) begin
          if (m_cnt < MAXC) m_cnt++;
          if (b == 8'hF3 && rl_prefix(b)) begin m_rep = 1; m_repne = 0; end
          if (b == 8'hF2 && rl_prefix(b)) begin m_repne = 1; m_rep = 0; end
          if (b == 8'hF0 && rl_prefix(b)) m_lock = 1;
        end else begin
          m_opcode = b; m_hold = 1; exp_q.push_back(b);
        end
      end
      pop_flag = bus.fifo_rd_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [7:0] b);
    src_q.push_back(b);
    present();
  endtask

  task automatic wait_valid(input int max, output int waited);
    waited = 0;
    while (!bus.opcode_valid && waited < max) begin cyc(); waited++; end
    check("valid_timeout", bus.opcode_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int w;
    bus.flush = 0; bus.opcode_ready = 1; bus.fifo_empty = 1; bus.fifo_data = 8'h00;
    cyc(2);
    reset_n = 1;
    cyc(1);

    // 2Eh, 8Bh: update in cycle 0, opcode valid two cycles later
    push(8'h2E); push(8'h8B);
    #1;
    check("t1_update", bus.update, 1);
    check("t1_ovr_in", bus.override_in, 1);
    wait_valid(10, w);
    check("t1_latency", w, 2);
    check("t1_opcode", bus.opcode, 8'h8B);
    check("t1_count", bus.prefix_count, 1);
    cyc(3);

    // 26h, 36h, 90h then 5 stalled cycles in HOLD
    bus.opcode_ready = 0;
    push(8'h26); push(8'h36); push(8'h90);
    wait_valid(10, w);
    check("t2_opcode", bus.opcode, 8'h90);
    check("t2_count", bus.prefix_count, 2);
    push(8'h55);
    cyc(5);
    check("t2_hold_valid", bus.opcode_valid, 1);
    check("t2_hold_opcode", bus.opcode, 8'h90);
    bus.opcode_ready = 1;
    cyc(1);
    check("t2_after_hs_valid", bus.opcode_valid, 0);
    check("t2_after_hs_count", bus.prefix_count, 0);
    check("t2_resume_rd_en", bus.fifo_rd_en, 1);
    cyc(4);

    // F3h, F2h, F0h, A4h
    bus.opcode_ready = 0;
    push(8'hF3); push(8'hF2); push(8'hF0); push(8'hA4);
    wait_valid(10, w);
`ifdef REP_LOCK_PREFIX_EN
    check("t3_opcode", bus.opcode, 8'hA4);
    check("t3_flags", {bus.rep, bus.repne, bus.lock}, 3'b011);
    check("t3_count", bus.prefix_count, 3);
`else
    check("t3_opcode", bus.opcode, 8'hF3);
    check("t3_flags", {bus.rep, bus.repne, bus.lock}, 3'b000);
    check("t3_count", bus.prefix_count, 0);
`endif
    bus.opcode_ready = 1;
    cyc(1);
    check("t3_clr_flags", {bus.rep, bus.repne, bus.lock}, 3'b000);
    check("t3_clr_count", bus.prefix_count, 0);
    cyc(12);

    // flush while 3Eh is about to pop
    push(8'h26); push(8'h3E);
    cyc(1);
    check("t4_count_pre", bus.prefix_count, 1);
    bus.flush = 1;
    #1;
    check("t4_flush_rd_en", bus.fifo_rd_en, 0);
    check("t4_flush_update", bus.update, 0);
    cyc(1);
    bus.flush = 0;
    check("t4_post_count", bus.prefix_count, 0);
    check("t4_post_valid", bus.opcode_valid, 0);
    push(8'hC3);
    cyc(5);

    // flush during HOLD keeps opcode
    bus.opcode_ready = 0;
    push(8'h8B);
    wait_valid(10, w);
    bus.flush = 1;
    cyc(1);
    bus.flush = 0;
    check("t5_valid", bus.opcode_valid, 0);
    check("t5_opcode", bus.opcode, 8'h8B);
    bus.opcode_ready = 1;
    cyc(2);

    // empty stall keeps the popped prefix
    push(8'h3E);
    cyc(1);
    starve = 1; push(8'h31);
    cyc(3);
    check("t6_stall_count", bus.prefix_count, 1);
    check("t6_stall_valid", bus.opcode_valid, 0);
    starve = 0; present();
    wait_valid(10, w);
    check("t6_opcode", bus.opcode, 8'h31);
    check("t6_count", bus.prefix_count, 1);
    cyc(3);

    // 17 x 26h saturates the count
    bus.opcode_ready = 0;
    for (int i = 0; i < 17; i++) push(8'h26);
    push(8'h88);
    wait_valid(40, w);
    check("t7_latency", w, 18);
    check("t7_count", bus.prefix_count, MAXC);
    check("t7_opcode", bus.opcode, 8'h88);
    bus.opcode_ready = 1;
    cyc(3);

    // reset during HOLD
    bus.opcode_ready = 0;
    push(8'h77);
    wait_valid(10, w);
    #1 reset_n = 0;
    #1;
    check("t8_valid", bus.opcode_valid, 0);
    check("t8_opcode", bus.opcode, 8'h00);
    check("t8_rd_en", bus.fifo_rd_en, 0);
    src_q.delete(); present();
    cyc(2);
    reset_n = 1;
    bus.opcode_ready = 1;
    push(8'h2E); push(8'h40);
    cyc(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
